// File: rtl/execute_div.sv
// execute_div -- iterative 32-bit integer divider for the execute stage.
//
// One radix-2 restoring step resolves one quotient bit per cycle. Signed
// commands divide operand magnitudes and fix the signs up afterwards.
//
// Ports
//   iCLOCK       in   clock, all state changes on the rising edge
//   iRESET_SYNC  in   synchronous active-high reset
//   iFLUSH       in   abort the operation in progress, return to idle
//   iVALID       in   request valid
//   oBUSY        out  request not accepted while high (low only in idle)
//   iCMD[1:0]    in   0=UDIV 1=UMOD 2=DIV(signed) 3=MOD(signed)
//   iDATA_0[31:0]in   dividend
//   iDATA_1[31:0]in   divisor
//   oVALID       out  result valid
//   iBUSY        in   downstream stall, result held while high
//   oDATA[31:0]  out  quotient or remainder
//   oFLAGS[4:0]  out  {sf, of, cf, pf, zf}
module execute_div #(
    parameter int P_ITER = 32
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iFLUSH,
    input  logic        iVALID,
    output logic        oBUSY,
    input  logic [1:0]  iCMD,
    input  logic [31:0] iDATA_0,
    input  logic [31:0] iDATA_1,
    output logic        oVALID,
    input  logic        iBUSY,
    output logic [31:0] oDATA,
    output logic [4:0]  oFLAGS
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Count value of the last restoring step; count 0 is the divide-by-zero check.
    localparam logic [5:0] LAST_STEP = 6'(P_ITER);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [31:0] raw_dividend_q, raw_dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        ovf_q, ovf_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  flags_q, flags_d;

    logic [32:0] shifted_s;
    logic        fits_s;
    logic [31:0] trial_rem_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;
    logic [31:0] result_s;
    logic [31:0] div0_result_s;

    // Condition flags derived from the result word.
    function automatic logic [4:0] make_flags(input logic [31:0] data, input logic of);
        return {data[31], of, 1'b0, data[0], (data == 32'd0)};
    endfunction

    // Restoring step: bring the next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        shifted_s   = {rem_q, quo_q[31]};
        fits_s      = (shifted_s >= {1'b0, divisor_q});
        // The remainder stays below the divisor, so the low 32 bits hold the exact difference.
        trial_rem_s = shifted_s[31:0] - divisor_q;
    end

    // Sign correction and quotient/remainder selection.
    always_comb begin
        quo_fix_s     = quo_neg_q ? (32'd0 - quo_q) : quo_q;
        rem_fix_s     = rem_neg_q ? (32'd0 - rem_q) : rem_q;
        result_s      = cmd_q[0] ? rem_fix_s : quo_fix_s;
        div0_result_s = cmd_q[0] ? raw_dividend_q : 32'hFFFF_FFFF;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cmd_d          = cmd_q;
        raw_dividend_d = raw_dividend_q;
        divisor_d      = divisor_q;
        quo_d          = quo_q;
        rem_d          = rem_q;
        quo_neg_d      = quo_neg_q;
        rem_neg_d      = rem_neg_q;
        ovf_d          = ovf_q;
        valid_d        = valid_q;
        data_d         = data_q;
        flags_d        = flags_q;

        if (iFLUSH) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iVALID) begin
                        state_d        = CALC;
                        cnt_d          = 6'd0;
                        cmd_d          = iCMD;
                        raw_dividend_d = iDATA_0;
                        divisor_d      = (iCMD[1] && iDATA_1[31]) ? (32'd0 - iDATA_1) : iDATA_1;
                        quo_d          = (iCMD[1] && iDATA_0[31]) ? (32'd0 - iDATA_0) : iDATA_0;
                        rem_d          = 32'd0;
                        quo_neg_d      = iCMD[1] && (iDATA_0[31] ^ iDATA_1[31]);
                        rem_neg_d      = iCMD[1] && iDATA_0[31];
                        ovf_d          = iCMD[1] && (iDATA_0 == 32'h8000_0000)
                                                 && (iDATA_1 == 32'hFFFF_FFFF);
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_q == 6'd0) begin
                        // First CALC cycle only screens for a zero divisor.
                        if (divisor_q == 32'd0) begin
                            data_d  = div0_result_s;
                            flags_d = make_flags(div0_result_s, 1'b1);
                            valid_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            cnt_d = 6'd1;
                        end
                    end else begin
                        rem_d = fits_s ? trial_rem_s : shifted_s[31:0];
                        quo_d = {quo_q[30:0], fits_s};
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == LAST_STEP) begin
                            state_d = FIX;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                FIX: begin
                    data_d  = result_s;
                    flags_d = make_flags(result_s, ovf_q);
                    valid_d = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                    if (!iBUSY) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q        <= IDLE;
            cnt_q          <= 6'd0;
            cmd_q          <= 2'd0;
            raw_dividend_q <= 32'd0;
            divisor_q      <= 32'd0;
            quo_q          <= 32'd0;
            rem_q          <= 32'd0;
            quo_neg_q      <= 1'b0;
            rem_neg_q      <= 1'b0;
            ovf_q          <= 1'b0;
            valid_q        <= 1'b0;
            busy_q         <= 1'b0;
            data_q         <= 32'd0;
            flags_q        <= 5'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmd_q          <= cmd_d;
            raw_dividend_q <= raw_dividend_d;
            divisor_q      <= divisor_d;
            quo_q          <= quo_d;
            rem_q          <= rem_d;
            quo_neg_q      <= quo_neg_d;
            rem_neg_q      <= rem_neg_d;
            ovf_q          <= ovf_d;
            valid_q        <= valid_d;
            busy_q         <= busy_d;
            data_q         <= data_d;
            flags_q        <= flags_d;
        end
    end

    assign oBUSY  = busy_q;
    assign oVALID = valid_q;
    assign oDATA  = data_q;
    assign oFLAGS = flags_q;

endmodule

// File: tb/tb_execute_div.sv
// Testbench for execute_div: directed vector table, stall/flush/reset
// sequences, and randomized operations against an arithmetic reference.
module tb_execute_div;

    logic        iCLOCK      = 1'b0;
    logic        iRESET_SYNC = 1'b1;
    logic        iFLUSH      = 1'b0;
    logic        iVALID      = 1'b0;
    logic        iBUSY       = 1'b0;
    logic [1:0]  iCMD        = 2'd0;
    logic [31:0] iDATA_0     = 32'd0;
    logic [31:0] iDATA_1     = 32'd0;
    logic        oBUSY;
    logic        oVALID;
    logic [31:0] oDATA;
    logic [4:0]  oFLAGS;

    int vectors     = 0;
    int miscompares = 0;

    always #5 iCLOCK = ~iCLOCK;

    execute_div #(.P_ITER(32)) dut (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .iFLUSH      (iFLUSH),
        .iVALID      (iVALID),
        .oBUSY       (oBUSY),
        .iCMD        (iCMD),
        .iDATA_0     (iDATA_0),
        .iDATA_1     (iDATA_1),
        .oVALID      (oVALID),
        .iBUSY       (iBUSY),
        .oDATA       (oDATA),
        .oFLAGS      (oFLAGS)
    );

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic [4:0]  exp_flags;
        int          exp_lat;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain integer division semantics plus the two special cases.
    function automatic logic [36:0] model(input logic [1:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] res;
        logic        of;
        of = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            of = 1'b1;
        end else if (!cmd[1]) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q  = 32'h8000_0000;
            r  = 32'd0;
            of = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        res = cmd[0] ? r : q;
        return {res, res[31], of, 1'b0, res[0], (res == 32'd0)};
    endfunction

    // Drive one request and return just after its accept edge.
    task automatic start_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b);
        @(negedge iCLOCK);
        iVALID  = 1'b1;
        iCMD    = cmd;
        iDATA_0 = a;
        iDATA_1 = b;
        @(posedge iCLOCK);
        #1;
        iVALID = 1'b0;
    endtask

    // Count edges until oVALID, starting from a given count; bounded.
    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (oVALID !== 1'b1 && lat < 100) begin
            @(posedge iCLOCK);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_d,
                          input logic [4:0] exp_f, input int exp_lat);
        int lat;
        start_op(cmd, a, b);
        wait_valid(0, lat);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_data"}, 64'(oDATA), 64'(exp_d));
        check({name, "_flags"}, 64'(oFLAGS), 64'(exp_f));
        @(posedge iCLOCK);
        #1;
        check({name, "_idle"}, {62'd0, oBUSY, oVALID}, 64'd0);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [1:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [36:0] m;

        tbl[0]  = '{2'd0, 32'd100,         32'd7,           32'd14,          5'b00000, 34};
        tbl[1]  = '{2'd1, 32'd100,         32'd7,           32'd2,           5'b00000, 34};
        tbl[2]  = '{2'd2, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   5'b10010, 34};
        tbl[3]  = '{2'd3, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   5'b10010, 34};
        tbl[4]  = '{2'd0, 32'd5,           32'd0,           32'hFFFF_FFFF,   5'b11010, 1};
        tbl[5]  = '{2'd1, 32'd5,           32'd0,           32'd5,           5'b01010, 1};
        tbl[6]  = '{2'd2, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   5'b11000, 34};
        tbl[7]  = '{2'd3, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           5'b01001, 34};
        tbl[8]  = '{2'd2, 32'd0,           32'd5,           32'd0,           5'b00001, 34};
        tbl[9]  = '{2'd3, 32'hFFFF_FFF9,   32'd0,           32'hFFFF_FFF9,   5'b11010, 1};
        tbl[10] = '{2'd0, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   5'b10010, 34};
        tbl[11] = '{2'd2, 32'd100,         32'hFFFF_FFF9,   32'hFFFF_FFF2,   5'b10000, 34};

        // Reset state
        repeat (3) @(posedge iCLOCK);
        #1;
        check("reset_state", {27'd0, oVALID, oBUSY, oFLAGS, oDATA}, 64'd0);
        iRESET_SYNC = 1'b0;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].cmd, tbl[i].a, tbl[i].b,
                   tbl[i].exp_data, tbl[i].exp_flags, tbl[i].exp_lat);
        end

        // Downstream stall in DONE, then back-to-back request with ignored iVALIDs
        iBUSY = 1'b1;
        start_op(2'd0, 32'd1000, 32'd10);
        wait_valid(0, lat);
        check("hold_lat", 64'(lat), 64'd34);
        for (int i = 0; i < 10; i++) begin
            @(posedge iCLOCK);
            #1;
            check("hold_stable", {27'd0, oVALID, oBUSY, oFLAGS, oDATA},
                  {27'd0, 1'b1, 1'b1, 5'b00000, 32'd100});
        end
        @(negedge iCLOCK);
        iBUSY   = 1'b0;
        iVALID  = 1'b1;
        iCMD    = 2'd0;
        iDATA_0 = 32'd50;
        iDATA_1 = 32'd5;
        @(posedge iCLOCK);
        #1;
        check("release_idle", {62'd0, oVALID, oBUSY}, 64'd0);
        @(posedge iCLOCK);
        #1;
        check("b2b_accept", 64'(oBUSY), 64'd1);
        iVALID = 1'b0;
        lat = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLOCK);
            iVALID  = 1'b1;
            iCMD    = 2'd3;
            iDATA_0 = $urandom;
            iDATA_1 = $urandom;
            @(posedge iCLOCK);
            #1;
            lat++;
        end
        iVALID = 1'b0;
        wait_valid(lat, lat);
        check("b2b_lat", 64'(lat), 64'd34);
        check("b2b_data", 64'(oDATA), 64'd10);
        @(posedge iCLOCK);
        #1;

        // Flush at CALC cycle 5 with a simultaneous request
        start_op(2'd0, 32'd100, 32'd7);
        repeat (4) @(posedge iCLOCK);
        @(negedge iCLOCK);
        iFLUSH  = 1'b1;
        iVALID  = 1'b1;
        iDATA_0 = 32'd77;
        iDATA_1 = 32'd7;
        @(posedge iCLOCK);
        #1;
        check("flush_idle", {62'd0, oBUSY, oVALID}, 64'd0);
        iFLUSH = 1'b0;
        iVALID = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge iCLOCK);
            #1;
            seen = seen | oVALID | oBUSY;
        end
        check("flush_quiet", 64'(seen), 64'd0);

        // Reset at CALC cycle 20 beats flush and valid
        start_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        repeat (19) @(posedge iCLOCK);
        @(negedge iCLOCK);
        iRESET_SYNC = 1'b1;
        iFLUSH      = 1'b1;
        iVALID      = 1'b1;
        @(posedge iCLOCK);
        #1;
        check("reset_abort", {27'd0, oVALID, oBUSY, oFLAGS, oDATA}, 64'd0);
        iRESET_SYNC = 1'b0;
        iFLUSH      = 1'b0;
        iVALID      = 1'b0;
        run_op("after_reset", 2'd0, 32'd9, 32'd3, 32'd3, 5'b00010, 34);

        // Randomized operations against the reference
        for (int i = 0; i < 30; i++) begin
            rc = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? (32'd0 - 32'($urandom_range(1, 50)))
                                              : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'd0 - 32'($urandom_range(1, 9));
                default: rb = 32'($urandom);
            endcase
            m = model(rc, ra, rb);
            run_op($sformatf("rand%0d", i), rc, ra, rb, m[36:5], m[4:0],
                   (rb == 32'd0) ? 1 : 34);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
